// File: rtl/fifo_word_reader_pkg.sv
// Shared types and constants for the FIFO word reader.
// Holds the FSM state type, the word geometry and the keep-mask helper.
package fifo_word_reader_pkg;

    typedef enum logic {
        S_FILL = 1'b0,
        S_PUSH = 1'b1
    } state_t;

    localparam int WORD_BYTES   = 4;
    localparam int BYTE_W       = 8;
    localparam int WORD_W       = WORD_BYTES * BYTE_W;
    localparam int CNT_W        = 3;
    localparam int FLUSH_CYCLES = 16;

    localparam logic [WORD_BYTES-1:0] KEEP_FULL = 4'hF;

    // Lanes 0..cnt-1 are valid; a count of 4 or more means the whole word.
    function automatic logic [WORD_BYTES-1:0] keep_for(input logic [CNT_W-1:0] cnt);
        logic [WORD_BYTES-1:0] keep;
        case (cnt)
            3'd0:    keep = 4'h0;
            3'd1:    keep = 4'h1;
            3'd2:    keep = 4'h3;
            3'd3:    keep = 4'h7;
            default: keep = KEEP_FULL;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for the word stream: one word, valid/ready handshake.
// A word is loaded only when the register is free or its current word is being accepted.
module stream_out_reg
    import fifo_word_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  load,
    input  logic [WORD_W-1:0]     load_data,
    input  logic [WORD_BYTES-1:0] load_keep,
    input  logic                  m_ready,
    output logic [WORD_W-1:0]     m_data,
    output logic [WORD_BYTES-1:0] m_keep,
    output logic                  m_valid,
    output logic                  can_load
);

    assign can_load = !m_valid || m_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            m_data  <= '0;
            m_keep  <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= load_data;
            m_keep  <= load_keep;
            m_valid <= 1'b1;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_reader.sv
// Drains a byte FIFO with registered read data and packs bytes into 32-bit stream words.
// Optional partial-word flush after an idle timeout is enabled by defining FLUSH_TIMEOUT_EN.
module fifo_word_reader
    import fifo_word_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  fifo_empty,
    input  logic [BYTE_W-1:0]     fifo_dout,
    output logic                  fifo_rd_en,
    output logic [WORD_W-1:0]     m_data,
    output logic [WORD_BYTES-1:0] m_keep,
    output logic                  m_valid,
    input  logic                  m_ready
);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        byte_cnt;
    logic                    pending;
    logic [BYTE_W-1:0]       lanes [WORD_BYTES];
    logic                    word_done;
    logic                    flush;
    logic                    out_ready;
    logic                    out_load;
    logic [WORD_W-1:0]       load_data;
    logic [WORD_BYTES-1:0]   load_keep;

    // Bytes already held plus the one in flight must leave room in the word.
    assign fifo_rd_en = !srst && !fifo_empty && (state == S_FILL)
                        && ((byte_cnt + {{(CNT_W-1){1'b0}}, pending}) < 3'd4);

    // The fourth byte arriving this cycle completes the word; it goes straight
    // to the output register when that is free, which keeps 4 bytes per 5 cycles.
    assign word_done = (state == S_FILL) && pending && (byte_cnt == 3'd3);
    assign out_load  = ((state == S_PUSH) || word_done) && out_ready;

`ifdef FLUSH_TIMEOUT_EN
    logic [7:0] timer;
    logic       idle;

    assign idle  = (state == S_FILL) && (byte_cnt != '0) && !pending && fifo_empty;
    assign flush = idle && (timer == 8'(FLUSH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (srst || !idle || flush) begin
            timer <= '0;
        end else begin
            timer <= timer + 8'd1;
        end
    end

    assign load_keep = word_done ? KEEP_FULL : keep_for(byte_cnt);
`else
    assign flush     = 1'b0;
    assign load_keep = KEEP_FULL;
`endif

    always_comb begin
        load_data = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            load_data[i*BYTE_W +: BYTE_W] = lanes[i];
        end
        if (word_done) begin
            load_data[WORD_W-1 -: BYTE_W] = fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FILL: begin
                if ((word_done && !out_ready) || flush) begin
                    state_next = S_PUSH;
                end
            end
            S_PUSH: begin
                if (out_ready) begin
                    state_next = S_FILL;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    // Loading a word empties the packer; otherwise a returning read lands in the next lane.
    always_ff @(posedge clk) begin
        if (srst) begin
            byte_cnt <= '0;
            pending  <= 1'b0;
            for (int i = 0; i < WORD_BYTES; i++) begin
                lanes[i] <= '0;
            end
        end else begin
            pending <= fifo_rd_en;
            if (out_load) begin
                byte_cnt <= '0;
                for (int i = 0; i < WORD_BYTES; i++) begin
                    lanes[i] <= '0;
                end
            end else if (pending) begin
                lanes[byte_cnt[1:0]] <= fifo_dout;
                byte_cnt             <= byte_cnt + 3'd1;
            end
        end
    end

    stream_out_reg u_out (
        .clk       (clk),
        .srst      (srst),
        .load      (out_load),
        .load_data (load_data),
        .load_keep (load_keep),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_valid   (m_valid),
        .can_load  (out_ready)
    );

endmodule
